// File: rtl/mem_arbiter_if.sv
// Bundle of the arbiter's slot counter, VGA fetch, CPU handshake and memory port signals.
// master: the arbiter side. slave: the environment (VGA controller, CPU, memory).
interface mem_arbiter_if #(
   parameter int unsigned DATAWIDTH = 16,
   parameter int unsigned ADDRWIDTH = 16
);

   // Slot counter and VGA fetch path
   logic [2:0]           acnt;
   logic [ADDRWIDTH-1:0] vga_addr;
   logic [DATAWIDTH-1:0] glyph_num;
   logic [DATAWIDTH-1:0] glyph_pixels;

   // CPU request/acknowledge port
   logic                 cpu_req;
   logic                 cpu_we;
   logic [ADDRWIDTH-1:0] cpu_addr;
   logic [DATAWIDTH-1:0] cpu_wdata;
   logic                 cpu_ack;
   logic [DATAWIDTH-1:0] cpu_rdata;

   // Shared memory port; mem_rdata is combinational from mem_addr
   logic [ADDRWIDTH-1:0] mem_addr;
   logic [DATAWIDTH-1:0] mem_wdata;
   logic                 mem_we;
   logic [DATAWIDTH-1:0] mem_rdata;

   modport master (
      output acnt,
      input  vga_addr,
      output glyph_num,
      output glyph_pixels,
      input  cpu_req,
      input  cpu_we,
      input  cpu_addr,
      input  cpu_wdata,
      output cpu_ack,
      output cpu_rdata,
      output mem_addr,
      output mem_wdata,
      output mem_we,
      input  mem_rdata
   );

   modport slave (
      input  acnt,
      output vga_addr,
      input  glyph_num,
      input  glyph_pixels,
      output cpu_req,
      output cpu_we,
      output cpu_addr,
      output cpu_wdata,
      input  cpu_ack,
      input  cpu_rdata,
      input  mem_addr,
      input  mem_wdata,
      input  mem_we,
      output mem_rdata
   );

endinterface

// File: rtl/mem_arbiter.sv
// Time-division arbiter for the single shared memory port.
// An 8-slot round: slots 0/1 fetch the frame-buffer word and the glyph-row pixels for the
// VGA controller, slots 2..7 serve one CPU port through a req/ack handshake.
module mem_arbiter #(
   parameter int unsigned DATAWIDTH = 16,
   parameter int unsigned ADDRWIDTH = 16
) (
   input logic           clk,
   input logic           rst,
   mem_arbiter_if.master bus
);

   logic [2:0]           acnt_q;
   logic [2:0]           acnt_d;
   logic [DATAWIDTH-1:0] glyph_num_q;
   logic [DATAWIDTH-1:0] glyph_pixels_q;
   logic [DATAWIDTH-1:0] cpu_rdata_q;
   // Set in the cycle after an access issues; doubles as the ack pulse and blocks
   // back-to-back issue, which gives the one-access-per-two-cycles ceiling.
   logic                 issued_q;

   logic                 cpu_slot;
   logic                 issue;
   logic [ADDRWIDTH-1:0] mem_addr;
   logic                 mem_we;

   // Free-running slot counter, modulo 8
   always_comb begin
      acnt_d = acnt_q + 3'd1;
   end

   // Slot decode, CPU issue qualification and memory port steering
   always_comb begin
      cpu_slot = (acnt_q >= 3'd2);
      issue    = cpu_slot & bus.cpu_req & ~issued_q;
      mem_addr = bus.vga_addr;
      mem_we   = 1'b0;
      if (cpu_slot) begin
         mem_addr = bus.cpu_addr;
      end
      if (issue) begin
         mem_we = bus.cpu_we;
      end
   end

   // Slot counter register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acnt_q <= 3'd0;
      end else begin
         acnt_q <= acnt_d;
      end
   end

   // VGA holding registers: frame word at the end of slot 0, pixel row at the end of slot 1
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         glyph_num_q    <= '0;
         glyph_pixels_q <= '0;
      end else begin
         if (acnt_q == 3'd0) begin
            glyph_num_q <= bus.mem_rdata;
         end
         if (acnt_q == 3'd1) begin
            glyph_pixels_q <= bus.mem_rdata;
         end
      end
   end

   // CPU completion: one-cycle ack after issue; read data captured only for reads
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         issued_q    <= 1'b0;
         cpu_rdata_q <= '0;
      end else begin
         issued_q <= issue;
         if (issue && !bus.cpu_we) begin
            cpu_rdata_q <= bus.mem_rdata;
         end
      end
   end

   // Output drive
   always_comb begin
      bus.acnt         = acnt_q;
      bus.glyph_num    = glyph_num_q;
      bus.glyph_pixels = glyph_pixels_q;
      bus.cpu_ack      = issued_q;
      bus.cpu_rdata    = cpu_rdata_q;
      bus.mem_addr     = mem_addr;
      bus.mem_wdata    = bus.cpu_wdata;
      bus.mem_we       = mem_we;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised bench for mem_arbiter with a scoreboard of expected CPU acks and a
// continuously checking monitor for the slot counter, VGA latches and memory port.
module tb_mem_arbiter;

   typedef struct {
      int          ack_cyc;
      bit          rd;
      logic [15:0] data;
   } exp_t;

   logic clk;
   logic rst;

   mem_arbiter_if #(.DATAWIDTH(16), .ADDRWIDTH(16)) bus ();

   mem_arbiter #(.DATAWIDTH(16), .ADDRWIDTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   logic [15:0] mem     [0:4095];
   logic [15:0] ref_mem [0:4095];

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc;
   int          prev_ack = -1;
   int          exp_we_cyc = -1;
   logic [15:0] exp_waddr = '0;
   logic [15:0] exp_wdata = '0;
   logic [15:0] gn_exp = '0;
   logic [15:0] gp_exp = '0;
   logic [15:0] last_rd = '0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycles since reset release; its value modulo 8 is the slot the DUT should be in
   always @(posedge clk or negedge rst) begin
      if (!rst) cyc <= 0;
      else      cyc <= cyc + 1;
   end

   function automatic logic [15:0] init_val(input int a);
      logic [31:0] v;
      if (a == 32'h0100) return 16'h1234;
      if (a == 32'h0012) return 16'hA5C3;
      v = a * 40503;
      return v[15:0] ^ 16'h5A5A;
   endfunction

   // Memory model: combinational read, write at the clock edge
   assign bus.mem_rdata = mem[bus.mem_addr[11:0]];
   always @(posedge clk) begin
      if (rst && bus.mem_we) mem[bus.mem_addr[11:0]] <= bus.mem_wdata;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // VGA address source: fixed test addresses early on, then random ROM-region addresses
   initial begin
      bus.vga_addr = 16'h0100;
      forever begin
         @(posedge clk);
         #1;
         if (cyc < 48) bus.vga_addr = ((cyc % 8) == 1) ? 16'h0012 : 16'h0100;
         else          bus.vga_addr = 16'h0800 + 16'($urandom_range(0, 2047));
      end
   end

   // Monitor: samples on the falling edge
   always @(negedge clk) begin
      if (rst) begin
         chk("acnt", {29'd0, bus.acnt}, cyc % 8);
         chk("glyph_num", {16'd0, bus.glyph_num}, {16'd0, gn_exp});
         chk("glyph_pixels", {16'd0, bus.glyph_pixels}, {16'd0, gp_exp});
         if ((cyc % 8) == 0) gn_exp = ref_mem[bus.vga_addr[11:0]];
         if ((cyc % 8) == 1) gp_exp = ref_mem[bus.vga_addr[11:0]];
         if ((cyc % 8) < 2) begin
            chk("mem_we_vga_slot", {31'd0, bus.mem_we}, 32'd0);
            chk("mem_addr_vga", {16'd0, bus.mem_addr}, {16'd0, bus.vga_addr});
         end else begin
            chk("mem_addr_cpu", {16'd0, bus.mem_addr}, {16'd0, bus.cpu_addr});
         end
         if (bus.mem_we) begin
            chk("mem_we_cycle", cyc, exp_we_cyc);
            chk("mem_waddr", {16'd0, bus.mem_addr}, {16'd0, exp_waddr});
            chk("mem_wdata", {16'd0, bus.mem_wdata}, {16'd0, exp_wdata});
         end
         if (bus.cpu_ack) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_ack at cycle %0d: got ack expected none", cyc);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("ack_cycle", cyc, e.ack_cyc);
               if (e.rd) last_rd = e.data;
               chk(e.rd ? "rdata" : "rdata_hold_on_write", {16'd0, bus.cpu_rdata},
                   {16'd0, last_rd});
            end
         end
      end
   end

   task automatic wait_slot(input int s);
      bit hit = 0;
      for (int k = 0; k < 16 && !hit; k++) begin
         @(posedge clk);
         #1;
         if ((cyc % 8) == s) hit = 1;
      end
      if (!hit) begin
         n_cmp++;
         n_err++;
         $display("FAIL wait_slot: got no slot %0d expected within 16 cycles", s);
      end
   endtask

   // Present one request in the current cycle; model its issue slot and push the expectation
   task automatic do_req(input bit we, input logic [15:0] addr, input logic [15:0] wdata,
                         input bit hold);
      int   i;
      exp_t e;
      bit   got = 0;
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = we;
      bus.cpu_addr  = addr;
      bus.cpu_wdata = wdata;
      i = cyc;
      while ((i % 8) < 2 || i == prev_ack) i++;
      e.ack_cyc = i + 1;
      e.rd      = !we;
      e.data    = ref_mem[addr[11:0]];
      sb.push_back(e);
      if (we) begin
         ref_mem[addr[11:0]] = wdata;
         exp_we_cyc = i;
         exp_waddr  = addr;
         exp_wdata  = wdata;
      end
      for (int k = 0; k < 24 && !got; k++) begin
         @(posedge clk);
         #1;
         if (bus.cpu_ack) got = 1;
      end
      if (!got) begin
         n_cmp++;
         n_err++;
         $display("FAIL ack_timeout: got no ack expected one within 24 cycles");
         sb.delete();
      end else begin
         prev_ack = cyc;
      end
      exp_we_cyc = -1;
      if (!hold) bus.cpu_req = 1'b0;
   endtask

   task automatic check_reset_state();
      chk("rst_acnt", {29'd0, bus.acnt}, 32'd0);
      chk("rst_cpu_ack", {31'd0, bus.cpu_ack}, 32'd0);
      chk("rst_glyph_num", {16'd0, bus.glyph_num}, 32'd0);
      chk("rst_glyph_pixels", {16'd0, bus.glyph_pixels}, 32'd0);
      chk("rst_cpu_rdata", {16'd0, bus.cpu_rdata}, 32'd0);
      chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
      chk("rst_mem_addr", {16'd0, bus.mem_addr}, {16'd0, bus.vga_addr});
   endtask

   task automatic release_reset();
      sb.delete();
      gn_exp     = '0;
      gp_exp     = '0;
      last_rd    = '0;
      prev_ack   = -1;
      exp_we_cyc = -1;
      @(posedge clk);
      #2;
      rst = 1'b1;
   endtask

   initial begin
      bus.cpu_req   = 1'b0;
      bus.cpu_we    = 1'b0;
      bus.cpu_addr  = '0;
      bus.cpu_wdata = '0;
      for (int a = 0; a < 4096; a++) begin
         mem[a]     = init_val(a);
         ref_mem[a] = init_val(a);
      end
      rst = 1'b0;
      #1;
      check_reset_state();
      repeat (2) @(posedge clk);
      release_reset();

      // Write at slot 2, then read it back with the request raised in slot 0
      wait_slot(2);
      do_req(1'b1, 16'h0400, 16'hBEEF, 1'b0);
      wait_slot(0);
      do_req(1'b0, 16'h0400, 16'h0000, 1'b0);

      // Request held for a whole round: issues at 2, 4, 6
      wait_slot(2);
      do_req(1'b0, 16'h0410, 16'h0000, 1'b1);
      do_req(1'b1, 16'h0411, 16'h1357, 1'b1);
      do_req(1'b0, 16'h0411, 16'h0000, 1'b0);

      // Issue at slot 7 acks in slot 0; the follow-on request waits for slot 2
      wait_slot(7);
      do_req(1'b0, 16'h0400, 16'h0000, 1'b1);
      do_req(1'b0, 16'h0410, 16'h0000, 1'b0);

      // Randomised traffic over a small address window to get read-after-write hits
      for (int n = 0; n < 120; n++) begin
         bit hold;
         hold = ($urandom_range(0, 2) == 0) && (n != 119);
         do_req(1'($urandom_range(0, 1)), 16'h0400 + 16'($urandom_range(0, 63)),
                16'($urandom), hold);
         if (!hold) begin
            repeat ($urandom_range(0, 3)) begin
               @(posedge clk);
               #1;
            end
         end
      end

      // Asynchronous reset during an ack cycle with the request still held
      wait_slot(4);
      bus.cpu_req  = 1'b1;
      bus.cpu_we   = 1'b0;
      bus.cpu_addr = 16'h0420;
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      check_reset_state();
      bus.cpu_req = 1'b0;
      repeat (2) @(posedge clk);
      release_reset();

      // Traffic after reset: counter restarts from 0 and requests are serviced again
      wait_slot(3);
      do_req(1'b0, 16'h0420, 16'h0000, 1'b0);
      do_req(1'b1, 16'h0421, 16'hC0DE, 1'b0);
      do_req(1'b0, 16'h0421, 16'h0000, 1'b0);

      repeat (10) @(posedge clk);
      #1;
      chk("scoreboard_drained", sb.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
